// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family: default geometry,
// read-mode encodings and the occupancy-count width helper.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Count spans 0..DEPTH inclusive, so it needs one bit more than the address.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable standard or FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [CW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags decode the registered pointers only, so a simultaneous push and pop
  // leaves count (and every flag) untouched with no intermediate value.
  assign count        = wptr_q - rptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Handshake: winc/rinc are requests, ~full/~empty act as ready, both taken
  // from the state before this edge; a request without ready is dropped and
  // raises the matching sticky error flag.
  assign wr_acc = winc & ~full;
  assign rd_acc = rinc & ~empty;

  always_comb begin
    wptr_d      = wr_acc ? wptr_q + ONE_C : wptr_q;
    rptr_d      = rd_acc ? rptr_q + ONE_C : rptr_q;
    overflow_d  = (winc & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rinc & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; zero when there is nothing to show.
      assign rdata  = empty ? '0 : ram_rdata;
      assign rvalid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
      logic                  rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rd_acc ? ram_rdata : rdata_q;
        rvalid_d = rd_acc;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Runs a standard-mode and an FWFT-mode FIFO side by side on shared stimulus,
// checked every cycle against a queue-based model plus literal spot checks.
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int AEMPTY = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          winc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_rvalid, f_rvalid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf, s_unf, f_unf;

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) u_std (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .clr_err(clr_err), .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full),
    .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
    .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) u_fwft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
    .clr_err(clr_err), .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full),
    .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [DW-1:0] m_std_rdata = '0;
  logic          m_std_rvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the accept rules.
  always @(posedge clk) begin
    bit m_full, m_empty, wacc, racc;
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_std_rdata = '0;
      m_std_rvalid = 1'b0;
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      wacc = winc && !m_full;
      racc = rinc && !m_empty;
      m_std_rvalid = racc;
      if (racc) m_std_rdata = exp_q.pop_front();
      if (wacc) exp_q.push_back(wdata);
      if (winc && m_full) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (rinc && m_empty) m_unf = 1'b1;
      else if (clr_err)    m_unf = 1'b0;
    end
  end

  // Compare process: every negedge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic [DW-1:0] head;
      n = exp_q.size();
      head = (n != 0) ? exp_q[0] : '0;
      chk("std_count", s_count, n);
      chk("fwft_count", f_count, n);
      chk("std_full", s_full, n == DEPTH);
      chk("fwft_full", f_full, n == DEPTH);
      chk("std_empty", s_empty, n == 0);
      chk("fwft_empty", f_empty, n == 0);
      chk("std_afull", s_afull, n >= AFULL);
      chk("fwft_afull", f_afull, n >= AFULL);
      chk("std_aempty", s_aempty, n <= AEMPTY);
      chk("fwft_aempty", f_aempty, n <= AEMPTY);
      chk("std_ovf", s_ovf, m_ovf);
      chk("fwft_ovf", f_ovf, m_ovf);
      chk("std_unf", s_unf, m_unf);
      chk("fwft_unf", f_unf, m_unf);
      chk("std_rvalid", s_rvalid, m_std_rvalid);
      chk("std_rdata", s_rdata, m_std_rdata);
      chk("fwft_rvalid", f_rvalid, n != 0);
      chk("fwft_rdata", f_rdata, head);
    end
  end

  // driver: apply inputs for one edge, return at the following negedge
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    winc = w; wdata = d; rinc = r; clr_err = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle();
    chk("lit_reset_count", s_count, 0);
    chk("lit_reset_empty", f_empty, 1);
    chk("lit_reset_rdata", f_rdata, 0);

    // fill to full, then overflow
    step(1, 8'h11, 0, 0);
    chk("lit_fwft_first", f_rdata, 8'h11);
    step(1, 8'h22, 0, 0);
    chk("lit_aempty_drop", s_aempty, 0);
    step(1, 8'h33, 0, 0);
    chk("lit_afull_rise", f_afull, 1);
    step(1, 8'h44, 0, 0);
    chk("lit_full", s_full, 1);
    step(1, 8'h55, 0, 0);
    chk("lit_ovf_set", s_ovf, 1);
    chk("lit_ovf_count", f_count, 4);

    // drain in order, then underflow
    step(0, 0, 1, 0);
    chk("lit_std_rd0", s_rdata, 8'h11);
    chk("lit_fwft_next", f_rdata, 8'h22);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("lit_std_rd3", s_rdata, 8'h44);
    chk("lit_drained", s_empty, 1);
    idle();
    chk("lit_rvalid_pulse", s_rvalid, 0);
    step(0, 0, 1, 0);
    chk("lit_unf_set", f_unf, 1);
    step(0, 0, 0, 1);
    chk("lit_clr", s_ovf | s_unf, 0);

    // simultaneous read/write at count 2, pointers wrap
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'hA2 + 8'(i), 1, 0);
    chk("lit_stream_count", s_count, 2);
    chk("lit_stream_std", s_rdata, 8'hA5);
    chk("lit_stream_fwft", f_rdata, 8'hA6);

    // full with both asserted, empty with both asserted
    step(1, 8'hB0, 0, 0);
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 1, 0);
    chk("lit_full_both_cnt", s_count, 3);
    chk("lit_full_both_ovf", s_ovf, 1);
    chk("lit_full_both_rd", s_rdata, 8'hA6);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 8'hC0, 1, 0);
    chk("lit_empty_both_cnt", f_count, 1);
    chk("lit_empty_both_unf", f_unf, 1);
    chk("lit_empty_both_rd", f_rdata, 8'hC0);

    // clear vs new overflow, then clear alone
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'hD0 + 8'(i), 0, 0);
    step(1, 8'hDF, 0, 1);
    chk("lit_set_beats_clr", s_ovf, 1);
    step(0, 0, 0, 1);
    chk("lit_clr_ovf", f_ovf, 0);

    // reset at count 3
    step(0, 0, 1, 0);
    chk("lit_pre_rst_cnt", s_count, 3);
    rst = 1'b1;
    step(1, 8'hEE, 1, 0);
    rst = 1'b0;
    chk("lit_rst_count", s_count, 0);
    chk("lit_rst_rdata", s_rdata, 0);
    chk("lit_rst_rvalid", s_rvalid, 0);

    // randomized phase with drifting write/read bias to visit full and empty
    for (int i = 0; i < 3000; i++) begin
      int wb, rb;
      wb = ((i / 150) % 2 == 0) ? 70 : 30;
      rb = 100 - wb;
      d = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 99) < wb, d, $urandom_range(0, 99) < rb,
           $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
